// File: rtl/serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder controller:
// FSM state encoding and the width of one adder slice.
package serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle for serial_adder_ctrl.
// op_sub is only present when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if
    import serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
);
    localparam int W = NIBBLE_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef SERIAL_ADDER_SUB_EN
    logic         op_sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    // Requester side: issues operands, observes status and result.
    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output op_sub,
`endif
        output start, a, b,
        input  busy, done, sum, cout
    );

    // Controller side.
    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  op_sub,
`endif
        input  start, a, b,
        output busy, done, sum, cout
    );

endinterface : serial_adder_ctrl_if

// File: rtl/serial_adder_ctrl_slice.sv
// four_bit_adder_cin: combinational 4-bit ripple-carry adder slice
// with carry-in, reused by the serial controller once per nibble.
module four_bit_adder_cin (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    // Ripple the carry bit by bit from the LSB.
    always_comb begin
        logic carry;
        carry = cin;
        sum   = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule : four_bit_adder_cin

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two (4*NIBBLES)-bit operands one nibble per
// cycle through a single 4-bit slice, framed by start/busy/done.
// Optional feature macro: SERIAL_ADDER_SUB_EN (adds op_sub, A - B).
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    state_e           state_q;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             c_q;
    logic [W-1:0]     sum_q;
    logic [W-1:0]     sum_d;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic [IDX_W+1:0]    shamt_s;
    logic [NIBBLE_W-1:0] nib_a_s;
    logic [NIBBLE_W-1:0] nib_b_s;
    logic [NIBBLE_W-1:0] slice_sum_s;
    logic                slice_cout_s;
    logic [W-1:0]        nib_mask_s;
    logic [W-1:0]        b_lat_s;
    logic                cin_s;

    // Operand nibble selection for the current slice position (idx*4).
    always_comb begin
        shamt_s = {idx_q, 2'b00};
        nib_a_s = NIBBLE_W'(a_q >> shamt_s);
        nib_b_s = NIBBLE_W'(b_q >> shamt_s);
    end

    four_bit_adder_cin u_slice (
        .a    (nib_a_s),
        .b    (nib_b_s),
        .cin  (c_q),
        .sum  (slice_sum_s),
        .cout (slice_cout_s)
    );

    // Merge the slice result into its nibble of the running sum.
    always_comb begin
        nib_mask_s = W'(4'hF) << shamt_s;
        sum_d      = (sum_q & ~nib_mask_s) | (W'(slice_sum_s) << shamt_s);
    end

    // B as latched and initial carry: subtract is A + ~B + 1.
    always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
        if (bus.op_sub) begin
            b_lat_s = ~bus.b;
            cin_s   = 1'b1;
        end else begin
            b_lat_s = bus.b;
            cin_s   = 1'b0;
        end
`else
        b_lat_s = bus.b;
        cin_s   = 1'b0;
`endif
    end

    // Controller FSM with operand latches, carry, sum and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.a;
                        b_q     <= b_lat_s;
                        c_q     <= cin_s;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q <= sum_d;
                    c_q   <= slice_cout_s;
                    if (idx_q == IDX_LAST) begin
                        cout_q  <= slice_cout_s;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_ONE;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    // Single-cycle pulse; start is deliberately ignored here.
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: a NIBBLES=4 instance for
// directed/random/protocol tests and a NIBBLES=1 instance for the
// exhaustive back-to-back sweep.
module tb_serial_adder_ctrl;

    localparam int N4 = 4;
    localparam int N1 = 1;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
`ifdef SERIAL_ADDER_SUB_EN
    logic tb_sub;
`endif

    serial_adder_ctrl_if #(.NIBBLES(N4)) bus4 ();
    serial_adder_ctrl_if #(.NIBBLES(N1)) bus1 ();

    serial_adder_ctrl #(.NIBBLES(N4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    serial_adder_ctrl #(.NIBBLES(N1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain W-bit arithmetic. For subtract, carry-out means "no borrow".
    function automatic logic [16:0] model4(input logic [15:0] a, input logic [15:0] b,
                                           input logic sub);
        logic [16:0] r;
        if (sub) begin
            r[15:0] = a - b;
            r[16]   = (a >= b);
        end else begin
            r = 17'(a) + 17'(b);
        end
        return r;
    endfunction

    // Issue one operation on the 4-nibble DUT and record what it reports.
    task automatic run_op4(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] s, output logic co,
                           output int done_cnt, output int busy_cnt, output int done_k);
        done_cnt = 0; busy_cnt = 0; done_k = -1; s = 16'h0000; co = 1'b0;
        bus4.start = 1'b1; bus4.a = a; bus4.b = b;
`ifdef SERIAL_ADDER_SUB_EN
        bus4.op_sub = tb_sub;
`endif
        @(posedge clk); #1;
        bus4.start = 1'b0;
        bus4.a = 16'($urandom);
        bus4.b = 16'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        bus4.op_sub = ~tb_sub;
`endif
        for (int k = 0; k < N4 + 6; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (bus4.busy) busy_cnt++;
            if (bus4.done) begin
                done_cnt++;
                if (done_k < 0) begin done_k = k; s = bus4.sum; co = bus4.cout; end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus4.start = 1'b0; bus4.a = 16'h0000; bus4.b = 16'h0000;
        bus1.start = 1'b0; bus1.a = 4'h0; bus1.b = 4'h0;
`ifdef SERIAL_ADDER_SUB_EN
        bus4.op_sub = 1'b0; bus1.op_sub = 1'b0; tb_sub = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus4.busy, bus4.done, bus4.cout, bus4.sum} !== 19'd0) begin
            bad++;
            $display("FAIL reset4: busy=%b done=%b cout=%b sum=%h, required all 0",
                     bus4.busy, bus4.done, bus4.cout, bus4.sum);
        end
        total++;
        if ({bus1.busy, bus1.done, bus1.cout, bus1.sum} !== 7'd0) begin
            bad++;
            $display("FAIL reset1: busy=%b done=%b cout=%b sum=%h, required all 0",
                     bus1.busy, bus1.done, bus1.cout, bus1.sum);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_add_directed();
        logic [15:0] s; logic co; int dc, bc, dk;
        run_op4(16'h1234, 16'h4321, s, co, dc, bc, dk);
        total++;
        if ({co, s} !== 17'h05555) begin
            bad++; $display("FAIL add_1234: got cout=%b sum=%h, required cout=0 sum=5555", co, s);
        end
        total++;
        if (dk !== N4) begin
            bad++; $display("FAIL add_latency: done seen %0d edges after accept, required %0d", dk, N4);
        end
        total++;
        if (bc !== N4) begin
            bad++; $display("FAIL add_busy: busy for %0d cycles, required %0d", bc, N4);
        end
        total++;
        if (dc !== 1) begin
            bad++; $display("FAIL add_done_count: %0d done pulses, required 1", dc);
        end
        total++;
        if (bus4.sum !== 16'h5555) begin
            bad++; $display("FAIL add_hold: sum=%h after idle, required 5555", bus4.sum);
        end
    endtask

    task automatic test_carry();
        logic [15:0] s; logic co; int dc, bc, dk;
        run_op4(16'hFFFF, 16'h0001, s, co, dc, bc, dk);
        total++;
        if ({co, s} !== 17'h10000 || dc !== 1) begin
            bad++; $display("FAIL carry_ffff_1: got cout=%b sum=%h dones=%0d, required 1 0000 1", co, s, dc);
        end
        run_op4(16'hFFFF, 16'hFFFF, s, co, dc, bc, dk);
        total++;
        if ({co, s} !== 17'h1FFFE || dc !== 1) begin
            bad++; $display("FAIL carry_ffff_ffff: got cout=%b sum=%h dones=%0d, required 1 fffe 1", co, s, dc);
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, s; logic co, sub; int dc, bc, dk;
        logic [16:0] exp;
        for (int n = 0; n < 24; n++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            sub = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            tb_sub = 1'($urandom);
            sub = tb_sub;
`endif
            exp = model4(a, b, sub);
            run_op4(a, b, s, co, dc, bc, dk);
            total++;
            if ({co, s} !== exp || dc !== 1 || dk !== N4) begin
                bad++;
                $display("FAIL random[%0d] a=%h b=%h sub=%b: got %b_%h dones=%0d at %0d, required %b_%h 1 at %0d",
                         n, a, b, sub, co, s, dc, dk, exp[16], exp[15:0], N4);
            end
        end
`ifdef SERIAL_ADDER_SUB_EN
        tb_sub = 1'b0;
`endif
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        logic [15:0] s; logic co; int dc, bc, dk;
        tb_sub = 1'b1;
        run_op4(16'h0007, 16'h0005, s, co, dc, bc, dk);
        total++;
        if ({co, s} !== 17'h10002) begin
            bad++; $display("FAIL sub_7_5: got cout=%b sum=%h, required 1 0002", co, s);
        end
        run_op4(16'h0005, 16'h0007, s, co, dc, bc, dk);
        total++;
        if ({co, s} !== 17'h0FFFE) begin
            bad++; $display("FAIL sub_5_7: got cout=%b sum=%h, required 0 fffe", co, s);
        end
        tb_sub = 1'b0;
    endtask
`endif

    task automatic test_start_while_busy();
        int dc, dk, busy_after;
        logic [15:0] s;
        dc = 0; dk = -1; busy_after = 0; s = 16'h0000;
        bus4.start = 1'b1; bus4.a = 16'h0001; bus4.b = 16'h0001;
        @(posedge clk); #1;
        // Re-request during the first RUN cycle with different operands.
        bus4.a = 16'h00FF; bus4.b = 16'h0001;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        for (int k = 1; k < N4 + 9; k++) begin
            if (bus4.done) begin
                dc++;
                if (dk < 0) begin dk = k; s = bus4.sum; end
            end
            if (dk >= 0 && k > dk && bus4.busy) busy_after++;
            // Re-request again while the done pulse is showing.
            bus4.start = (k == N4);
            @(posedge clk); #1;
        end
        bus4.start = 1'b0;
        total++;
        if (dc !== 1 || dk !== N4) begin
            bad++; $display("FAIL busy_start_done: %0d dones, first at %0d, required 1 at %0d", dc, dk, N4);
        end
        total++;
        if (s !== 16'h0002) begin
            bad++; $display("FAIL busy_start_sum: sum=%h, required 0002", s);
        end
        total++;
        if (busy_after !== 0) begin
            bad++; $display("FAIL busy_start_ignored: busy seen %0d cycles after done, required 0", busy_after);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        bus4.start = 1'b1; bus4.a = 16'h1111; bus4.b = 16'h1111;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        @(posedge clk); #1;
        // Now in the 2nd RUN cycle; low nibble already written.
        total++;
        if (bus4.sum !== 16'h0002 || bus4.busy !== 1'b1) begin
            bad++; $display("FAIL mid_partial: sum=%h busy=%b, required 0002 1", bus4.sum, bus4.busy);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++;
        if ({bus4.busy, bus4.done, bus4.cout, bus4.sum} !== 19'd0) begin
            bad++; $display("FAIL mid_reset: busy=%b done=%b cout=%b sum=%h, required all 0",
                            bus4.busy, bus4.done, bus4.cout, bus4.sum);
        end
        for (int k = 0; k < N4 + 4; k++) begin
            @(posedge clk); #1;
            if (bus4.done || bus4.busy) seen++;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL mid_no_done: activity in %0d cycles after reset, required 0", seen);
        end
    endtask

    task automatic test_back_to_back_n1();
        logic [4:0] exp;
        int err_res, err_hs;
        err_res = 0; err_hs = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                exp = 5'(a) + 5'(b);
                bus1.start = 1'b1; bus1.a = 4'(a); bus1.b = 4'(b);
                @(posedge clk); #1;
                bus1.start = 1'b0;
                bus1.a = 4'($urandom); bus1.b = 4'($urandom);
                if (bus1.busy !== 1'b1 || bus1.done !== 1'b0) err_hs++;
                @(posedge clk); #1;
                if (bus1.done !== 1'b1 || bus1.busy !== 1'b0) err_hs++;
                total++;
                if ({bus1.cout, bus1.sum} !== exp) begin
                    bad++; err_res++;
                    $display("FAIL sweep a=%h b=%h: got cout=%b sum=%h, required %b %h",
                             a, b, bus1.cout, bus1.sum, exp[4], exp[3:0]);
                end
                @(posedge clk); #1;
                if (bus1.done !== 1'b0 || bus1.busy !== 1'b0) err_hs++;
            end
        end
        total++;
        if (err_hs !== 0) begin
            bad++; $display("FAIL sweep_handshake: %0d busy/done errors, required 0", err_hs);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_add_directed();
        test_carry();
        test_start_while_busy();
        test_reset_mid();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random();
        test_back_to_back_n1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
